// File: rtl/mem_port_pkg.sv
// Shared definitions for the memory-port sequencer/arbiter.
//   - state_e       : sequencer states (idle, bus request issued, awaiting read data)
//   - LSN/LSW/LSH/LSB : LSU access width codes, identical to the decoder's encoding
//   - CTRL_*        : bit positions inside the 4-bit LSU control word
//   - DATA_W        : memory bus data width
package mem_port_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAITR = 2'd2
    } state_e;

    localparam logic [1:0] LSN = 2'b00;
    localparam logic [1:0] LSW = 2'b01;
    localparam logic [1:0] LSH = 2'b10;
    localparam logic [1:0] LSB = 2'b11;

    localparam int CTRL_LOAD   = 3;
    localparam int CTRL_SEXT   = 2;
    localparam int CTRL_WID_HI = 1;
    localparam int CTRL_WID_LO = 0;

endpackage

// File: rtl/mem_port_arbiter_lane_align.sv
// Byte-lane steering for LSU accesses (purely combinational).
// Write side (driven from the incoming request):
//   wr_width_i, wr_addr_lo_i, wr_data_i -> misaligned_o, be_o, wr_data_o
// Read side (driven from the registered transaction):
//   rd_width_i, rd_sext_i, rd_addr_lo_i, rd_data_i -> rd_data_o
module lsu_lane_align
    import mem_port_pkg::*;
(
    input  logic [1:0]        wr_width_i,
    input  logic [1:0]        wr_addr_lo_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              misaligned_o,
    output logic [3:0]        be_o,
    output logic [DATA_W-1:0] wr_data_o,
    input  logic [1:0]        rd_width_i,
    input  logic              rd_sext_i,
    input  logic [1:0]        rd_addr_lo_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [DATA_W-1:0] rd_data_o
);

    function automatic logic [DATA_W-1:0] ext8(input logic [7:0] b, input logic sext);
        logic signed [7:0] sb;
        sb = b;
        return {{(DATA_W-8){sext & sb[7]}}, b};
    endfunction

    function automatic logic [DATA_W-1:0] ext16(input logic [15:0] h, input logic sext);
        logic signed [15:0] sh;
        sh = h;
        return {{(DATA_W-16){sext & sh[15]}}, h};
    endfunction

    logic [DATA_W-1:0] rd_shifted;

    always_comb begin
        misaligned_o = 1'b0;
        be_o         = 4'b0000;
        wr_data_o    = '0;
        case (wr_width_i)
            LSW: begin
                misaligned_o = (wr_addr_lo_i != 2'b00);
                be_o         = 4'b1111;
                wr_data_o    = wr_data_i;
            end
            LSH: begin
                misaligned_o = wr_addr_lo_i[0];
                be_o         = wr_addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wr_data_o    = {2{wr_data_i[15:0]}};
            end
            LSB: begin
                be_o      = 4'b0001 << wr_addr_lo_i;
                wr_data_o = {4{wr_data_i[7:0]}};
            end
            default: ;
        endcase
    end

    // Bring the addressed lane down to bit 0 before masking/extending.
    assign rd_shifted = rd_data_i >> {rd_addr_lo_i, 3'b000};

    always_comb begin
        rd_data_o = '0;
        case (rd_width_i)
            LSW:     rd_data_o = rd_shifted;
            LSH:     rd_data_o = ext16(rd_shifted[15:0], rd_sext_i);
            LSB:     rd_data_o = ext8(rd_shifted[7:0], rd_sext_i);
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequencer and arbiter sharing one memory port between instruction fetch
// and the load/store unit; one transaction outstanding at a time.
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   fetch_req_i/addr_i, fetch_gnt_o      fetch request and combinational grant
//   fetch_valid_o, fetch_data_o          fetched word, one-cycle pulse
//   lsu_req_i/ctrl_i/addr_i/wdata_i      LSU request ({load, sext, width[1:0]})
//   lsu_gnt_o                            combinational LSU grant
//   lsu_valid_o, lsu_rdata_o, lsu_misaligned_o  LSU completion pulse
//   mem_req_o/we_o/addr_o/be_o/wdata_o   registered bus request
//   mem_ready_i, mem_rvalid_i, mem_rdata_i  bus accept and read return
module mem_port_arbiter
    import mem_port_pkg::*;
#(
    parameter int ADDR_W = 32
)
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic              fetch_gnt_o,
    output logic              fetch_valid_o,
    output logic [DATA_W-1:0] fetch_data_o,
    input  logic              lsu_req_i,
    input  logic [3:0]        lsu_ctrl_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    output logic              lsu_gnt_o,
    output logic              lsu_valid_o,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic              lsu_misaligned_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    state_e            state_q, state_d;
    logic              last_lsu_q, last_lsu_d;
    logic              is_fetch_q, is_fetch_d;
    logic [1:0]        wid_q, wid_d;
    logic              sext_q, sext_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
    logic              lsu_valid_q, lsu_valid_d;
    logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
    logic              lsu_mis_q, lsu_mis_d;

    logic              idle;
    logic              lsu_wins;
    logic              lsu_gnt;
    logic              fetch_gnt;
    logic [1:0]        req_wid;
    logic              al_misaligned;
    logic [3:0]        al_be;
    logic [DATA_W-1:0] al_wdata;
    logic [DATA_W-1:0] al_rdata;
    logic              fetch_addr_lo_unused;

    // Fetch addresses are word addresses; the low bits carry no meaning.
    assign fetch_addr_lo_unused = ^fetch_addr_i[1:0];

    assign req_wid = lsu_ctrl_i[CTRL_WID_HI:CTRL_WID_LO];

    lsu_lane_align u_align (
        .wr_width_i   (req_wid),
        .wr_addr_lo_i (lsu_addr_i[1:0]),
        .wr_data_i    (lsu_wdata_i),
        .misaligned_o (al_misaligned),
        .be_o         (al_be),
        .wr_data_o    (al_wdata),
        .rd_width_i   (wid_q),
        .rd_sext_i    (sext_q),
        .rd_addr_lo_i (addr_lo_q),
        .rd_data_i    (mem_rdata_i),
        .rd_data_o    (al_rdata)
    );

    // LSU has priority unless it also took the previous grant and fetch is
    // waiting; this alternates service when both keep requesting.
    assign idle      = (state_q == ST_IDLE);
    assign lsu_wins  = lsu_req_i && !(last_lsu_q && fetch_req_i);
    assign lsu_gnt   = idle && lsu_wins;
    assign fetch_gnt = idle && fetch_req_i && !lsu_wins;

    always_comb begin
        state_d       = state_q;
        last_lsu_d    = last_lsu_q;
        is_fetch_d    = is_fetch_q;
        wid_d         = wid_q;
        sext_d        = sext_q;
        addr_lo_d     = addr_lo_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_be_d      = mem_be_q;
        mem_wdata_d   = mem_wdata_q;
        fetch_valid_d = 1'b0;
        fetch_data_d  = '0;
        lsu_valid_d   = 1'b0;
        lsu_rdata_d   = '0;
        lsu_mis_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (lsu_gnt) begin
                    last_lsu_d = 1'b1;
                    // Width "none" and misaligned accesses never reach the bus.
                    if (req_wid == LSN || al_misaligned) begin
                        lsu_valid_d = 1'b1;
                        lsu_mis_d   = al_misaligned;
                    end else begin
                        state_d     = ST_ISSUE;
                        is_fetch_d  = 1'b0;
                        wid_d       = req_wid;
                        sext_d      = lsu_ctrl_i[CTRL_SEXT];
                        addr_lo_d   = lsu_addr_i[1:0];
                        mem_req_d   = 1'b1;
                        mem_we_d    = !lsu_ctrl_i[CTRL_LOAD];
                        mem_addr_d  = {lsu_addr_i[ADDR_W-1:2], 2'b00};
                        mem_be_d    = al_be;
                        mem_wdata_d = lsu_ctrl_i[CTRL_LOAD] ? '0 : al_wdata;
                    end
                end else if (fetch_gnt) begin
                    last_lsu_d  = 1'b0;
                    state_d     = ST_ISSUE;
                    is_fetch_d  = 1'b1;
                    wid_d       = LSW;
                    sext_d      = 1'b0;
                    addr_lo_d   = 2'b00;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = {fetch_addr_i[ADDR_W-1:2], 2'b00};
                    mem_be_d    = 4'b1111;
                    mem_wdata_d = '0;
                end
            end
            ST_ISSUE: begin
                if (mem_ready_i) begin
                    mem_req_d = 1'b0;
                    if (mem_we_q) begin
                        state_d     = ST_IDLE;
                        lsu_valid_d = 1'b1;
                    end else begin
                        state_d = ST_WAITR;
                    end
                end
            end
            ST_WAITR: begin
                if (mem_rvalid_i) begin
                    state_d = ST_IDLE;
                    if (is_fetch_q) begin
                        fetch_valid_d = 1'b1;
                        fetch_data_d  = mem_rdata_i;
                    end else begin
                        lsu_valid_d = 1'b1;
                        lsu_rdata_d = al_rdata;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            last_lsu_q    <= 1'b0;
            is_fetch_q    <= 1'b0;
            wid_q         <= LSN;
            sext_q        <= 1'b0;
            addr_lo_q     <= 2'b00;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_be_q      <= 4'b0000;
            mem_wdata_q   <= '0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
            lsu_valid_q   <= 1'b0;
            lsu_rdata_q   <= '0;
            lsu_mis_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_lsu_q    <= last_lsu_d;
            is_fetch_q    <= is_fetch_d;
            wid_q         <= wid_d;
            sext_q        <= sext_d;
            addr_lo_q     <= addr_lo_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_be_q      <= mem_be_d;
            mem_wdata_q   <= mem_wdata_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_data_q  <= fetch_data_d;
            lsu_valid_q   <= lsu_valid_d;
            lsu_rdata_q   <= lsu_rdata_d;
            lsu_mis_q     <= lsu_mis_d;
        end
    end

    assign fetch_gnt_o      = fetch_gnt;
    assign lsu_gnt_o        = lsu_gnt;
    assign fetch_valid_o    = fetch_valid_q;
    assign fetch_data_o     = fetch_data_q;
    assign lsu_valid_o      = lsu_valid_q;
    assign lsu_rdata_o      = lsu_rdata_q;
    assign lsu_misaligned_o = lsu_mis_q;
    assign mem_req_o        = mem_req_q;
    assign mem_we_o         = mem_we_q;
    assign mem_addr_o       = mem_addr_q;
    assign mem_be_o         = mem_be_q;
    assign mem_wdata_o      = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Stimulus pushes expected completions
// into per-requester queues; a monitor pops and compares on every Valid pulse.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        lsu_req;
    logic [3:0]  lsu_ctrl;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_gnt;
    logic        lsu_valid;
    logic [31:0] lsu_rdata;
    logic        lsu_mis;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] fetch_exp_q[$];
    logic [32:0] lsu_exp_q[$];
    logic [31:0] mon_fexp;
    logic [32:0] mon_lexp;

    mem_port_arbiter #(.ADDR_W(32)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .fetch_req_i      (fetch_req),
        .fetch_addr_i     (fetch_addr),
        .fetch_gnt_o      (fetch_gnt),
        .fetch_valid_o    (fetch_valid),
        .fetch_data_o     (fetch_data),
        .lsu_req_i        (lsu_req),
        .lsu_ctrl_i       (lsu_ctrl),
        .lsu_addr_i       (lsu_addr),
        .lsu_wdata_i      (lsu_wdata),
        .lsu_gnt_o        (lsu_gnt),
        .lsu_valid_o      (lsu_valid),
        .lsu_rdata_o      (lsu_rdata),
        .lsu_misaligned_o (lsu_mis),
        .mem_req_o        (mem_req),
        .mem_we_o         (mem_we),
        .mem_addr_o       (mem_addr),
        .mem_be_o         (mem_be),
        .mem_wdata_o      (mem_wdata),
        .mem_ready_i      (mem_ready),
        .mem_rvalid_i     (mem_rvalid),
        .mem_rdata_i      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Monitor: compare each completion against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (fetch_valid) begin
                if (fetch_exp_q.size() == 0) begin
                    chk("fetch_unexpected_pulse", 64'(fetch_valid), 64'd0);
                end else begin
                    mon_fexp = fetch_exp_q.pop_front();
                    chk("fetch_data", 64'(fetch_data), 64'(mon_fexp));
                end
            end else begin
                chk("fetch_data_idle_zero", 64'(fetch_data), 64'd0);
            end
            if (lsu_valid) begin
                if (lsu_exp_q.size() == 0) begin
                    chk("lsu_unexpected_pulse", 64'(lsu_valid), 64'd0);
                end else begin
                    mon_lexp = lsu_exp_q.pop_front();
                    chk("lsu_mis_rdata", 64'({lsu_mis, lsu_rdata}), 64'(mon_lexp));
                end
            end else begin
                chk("lsu_rdata_idle_zero", 64'({lsu_mis, lsu_rdata}), 64'd0);
            end
        end
    end

    initial begin
        rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
        lsu_req = 1'b0; lsu_ctrl = '0; lsu_addr = '0; lsu_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        // Reset values
        step(); step(); mid();
        chk("rst_ctl", 64'({fetch_gnt, fetch_valid, lsu_gnt, lsu_valid, lsu_mis, mem_req, mem_we, mem_be}), 64'd0);
        chk("rst_data", 64'({fetch_data, lsu_rdata}), 64'd0);
        chk("rst_mem", 64'({mem_addr, mem_wdata}), 64'd0);
        step(); rst = 1'b0;

        // LB sign-extend at 0x103
        step(); lsu_req = 1'b1; lsu_ctrl = 4'b1111; lsu_addr = 32'h103; mid();
        chk("lb_gnt", 64'({lsu_gnt, fetch_gnt}), 64'(2'b10));
        lsu_exp_q.push_back({1'b0, 32'hFFFF_FF80});
        step(); lsu_req = 1'b0; mem_ready = 1'b1; mid();
        chk("lb_bus_ctl", 64'({mem_req, mem_we, mem_be}), 64'(6'b1_0_1000));
        chk("lb_addr", 64'(mem_addr), 64'h100);
        step(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80FF_FF00; mid();
        chk("lb_req_drop", 64'({mem_req, lsu_valid}), 64'd0);
        step(); mem_rvalid = 1'b0; mid();
        chk("lb_valid_lat", 64'(lsu_valid), 64'd1);

        // SH store at 0x22
        step(); lsu_req = 1'b1; lsu_ctrl = 4'b0010; lsu_addr = 32'h22; lsu_wdata = 32'h1234_ABCD; mid();
        chk("sh_gnt", 64'({lsu_gnt, fetch_gnt}), 64'(2'b10));
        lsu_exp_q.push_back({1'b0, 32'h0});
        step(); lsu_req = 1'b0; mem_ready = 1'b1; mid();
        chk("sh_bus_ctl", 64'({mem_req, mem_we, mem_be}), 64'(6'b1_1_1100));
        chk("sh_wdata", 64'(mem_wdata), 64'hABCD_ABCD);
        chk("sh_addr", 64'(mem_addr), 64'h20);
        step(); mem_ready = 1'b0; mid();
        chk("sh_valid_lat", 64'({lsu_valid, mem_req}), 64'(2'b10));

        // Misaligned LW, misaligned LH, width none
        step(); lsu_req = 1'b1; lsu_ctrl = 4'b1001; lsu_addr = 32'h102; mid();
        chk("lw_mis_gnt", 64'(lsu_gnt), 64'd1);
        lsu_exp_q.push_back({1'b1, 32'h0});
        step(); lsu_req = 1'b0; mid();
        chk("lw_mis_resp", 64'({mem_req, lsu_valid, lsu_mis}), 64'(3'b011));
        step(); lsu_req = 1'b1; lsu_ctrl = 4'b1110; lsu_addr = 32'h101; mid();
        chk("lh_mis_gnt", 64'(lsu_gnt), 64'd1);
        lsu_exp_q.push_back({1'b1, 32'h0});
        step(); lsu_req = 1'b0; mid();
        chk("lh_mis_resp", 64'({mem_req, lsu_valid, lsu_mis}), 64'(3'b011));
        step(); lsu_req = 1'b1; lsu_ctrl = 4'b1000; lsu_addr = 32'h55; mid();
        chk("none_gnt", 64'(lsu_gnt), 64'd1);
        lsu_exp_q.push_back({1'b0, 32'h0});
        step(); lsu_req = 1'b0; mid();
        chk("none_resp", 64'({mem_req, lsu_valid, lsu_mis}), 64'(3'b010));

        // Arbitration from a fresh reset: LSU, fetch, LSU
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        step(); lsu_req = 1'b1; fetch_req = 1'b1; lsu_ctrl = 4'b1001; lsu_addr = 32'h200; fetch_addr = 32'h1000; mid();
        chk("arb1_gnt", 64'({lsu_gnt, fetch_gnt}), 64'(2'b10));
        lsu_exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        step(); mem_ready = 1'b1; mid();
        chk("arb_issue_nognt", 64'({lsu_gnt, fetch_gnt}), 64'd0);
        step(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; mid();
        chk("arb_waitr_nognt", 64'({lsu_gnt, fetch_gnt}), 64'd0);
        step(); mem_rvalid = 1'b0; mid();
        chk("arb2_gnt", 64'({lsu_valid, lsu_gnt, fetch_gnt}), 64'(3'b101));
        fetch_exp_q.push_back(32'h0011_2233);
        step(); mem_ready = 1'b1; lsu_ctrl = 4'b1010; lsu_addr = 32'h202; mid();
        chk("fetch_bus_ctl", 64'({mem_req, mem_we, mem_be}), 64'(6'b1_0_1111));
        chk("fetch_addr", 64'(mem_addr), 64'h1000);
        step(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0011_2233; mid();
        step(); mem_rvalid = 1'b0; mid();
        chk("arb3_gnt", 64'({fetch_valid, lsu_gnt, fetch_gnt}), 64'(3'b110));
        lsu_exp_q.push_back({1'b0, 32'h0000_8001});
        step(); lsu_req = 1'b0; fetch_req = 1'b0; mem_ready = 1'b1; mid();
        chk("lhu_addr_be", 64'({mem_addr, mem_be}), 64'({32'h200, 4'b1100}));
        step(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h8001_CAFE; mid();
        step(); mem_rvalid = 1'b0; mid();
        chk("lhu_valid", 64'(lsu_valid), 64'd1);

        // Reset while waiting for fetch read data
        step(); fetch_req = 1'b1; fetch_addr = 32'h2003; mid();
        chk("rf_gnt", 64'({lsu_gnt, fetch_gnt}), 64'(2'b01));
        step(); fetch_req = 1'b0; mem_ready = 1'b1; mid();
        chk("rf_addr", 64'(mem_addr), 64'h2000);
        step(); mem_ready = 1'b0; rst = 1'b1; mid();
        step(); rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55; mid();
        chk("rf_idle", 64'({mem_req, mem_we, mem_be, fetch_valid}), 64'd0);
        chk("rf_addr_clr", 64'(mem_addr), 64'd0);
        step(); mem_rvalid = 1'b0; mid();
        chk("rf_no_valid", 64'(fetch_valid), 64'd0);

        // Bus stalls in ISSUE for 5 cycles with fetch pending
        step(); lsu_req = 1'b1; lsu_ctrl = 4'b0011; lsu_addr = 32'h301; lsu_wdata = 32'h0000_00A5; mid();
        chk("sb_gnt", 64'({lsu_gnt, fetch_gnt}), 64'(2'b10));
        lsu_exp_q.push_back({1'b0, 32'h0});
        step(); lsu_req = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h3000;
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("stall_ctl", 64'({mem_req, mem_we, mem_be, lsu_gnt, fetch_gnt}), 64'(8'b1_1_0010_00));
            chk("stall_addr", 64'(mem_addr), 64'h300);
            chk("stall_wdata", 64'(mem_wdata), 64'hA5A5_A5A5);
            step();
        end
        mem_ready = 1'b1; fetch_req = 1'b0; mid();
        chk("stall_accept", 64'({mem_req, mem_addr, mem_be}), 64'({1'b1, 32'h300, 4'b0010}));
        step(); mem_ready = 1'b0; mid();
        chk("stall_valid", 64'(lsu_valid), 64'd1);

        step(); step(); mid();
        chk("sb_lsu_drain", 64'(lsu_exp_q.size()), 64'd0);
        chk("sb_fetch_drain", 64'(fetch_exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
